// File: rtl/frame_scheduler_pkg.sv
// Shared types for the frame scheduler: fixed-point scalar, vec3 camera vector, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_scheduler_pkg;

    // Q8.8 signed fixed point, shared with the ray marcher and user control.
    localparam int FP_WIDTH = 16;
    localparam int FP_FRAC  = 8;

    typedef logic signed [FP_WIDTH-1:0] fp_t;

    localparam fp_t FP_ZERO = 16'sh0000;
    localparam fp_t FP_ONE  = 16'sh0100;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3;

    localparam vec3 VEC3_ZERO = '{x: FP_ZERO, y: FP_ZERO, z: FP_ZERO};

    // Exposed here so benches and debug logic can name the scheduler states.
    typedef enum logic [2:0] {
        SCHED_IDLE        = 3'd0,
        SCHED_START       = 3'd1,
        SCHED_RENDER      = 3'd2,
        SCHED_WAIT_VBLANK = 3'd3,
        SCHED_SWAP        = 3'd4
    } sched_state_t;

endpackage

// File: rtl/frame_scheduler_edge_counter.sv
// Rising-edge detector plus 8-bit saturating edge counter with a clear that still counts a same-cycle edge.
// Latency: count reflects an edge one cycle after the edge is sampled.
// Backpressure: none; ports: core_clk, rst (sync, active-high), level in, clear in, count out.
module frame_scheduler_edge_counter (
    input  logic       core_clk,
    input  logic       rst,
    input  logic       level,
    input  logic       clear,
    output logic [7:0] count
);

    logic level_q;
    logic rise;

    assign rise = level & ~level_q;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            level_q <= 1'b0;
            count   <= 8'd0;
        end else begin
            level_q <= level;
            if (clear) begin
                // An edge in the clearing cycle belongs to the next frame.
                count <= {7'd0, rise};
            end else if (rise && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: starts ray_marcher frames, swaps buffers only in vblank, aborts renders on timeout.
// Latency: render_start_out 2 cycles after reset release; swap 2 cycles after render_done_in if already in vblank.
// Backpressure: pause_in holds IDLE between frames (an in-flight frame completes); ports: clk_in, rst_in,
//   pause_in, vblank_in, render_done_in, cam_pos_in/cam_dir_in in; pos_vec_out, dir_vec_out,
//   render_start_out, swap_buffers_out, frames_out, vblanks_per_frame_out, timeout_out out.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 67108864,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      pause_in,
    input  logic                      vblank_in,
    input  logic                      render_done_in,
    input  vec3                       cam_pos_in,
    input  vec3                       cam_dir_in,
    output vec3                       pos_vec_out,
    output vec3                       dir_vec_out,
    output logic                      render_start_out,
    output logic                      swap_buffers_out,
    output logic [FRAME_CNT_BITS-1:0] frames_out,
    output logic [7:0]                vblanks_per_frame_out,
    output logic                      timeout_out
);

    localparam int TMO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic [TMO_BITS-1:0] render_cnt;
    logic                armed;
    logic                timeout_hit;
    logic                swap_now;
    logic [7:0]          vblank_edges;

    assign render_start_out = (state == SCHED_START);
    assign swap_now         = (state == SCHED_SWAP);
    assign swap_buffers_out = swap_now;

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            SCHED_IDLE: begin
                // armed keeps the first post-reset START at least two cycles after release.
                if (armed && !pause_in) begin
                    state_nxt = SCHED_START;
                end
            end
            SCHED_START: begin
                state_nxt = SCHED_RENDER;
            end
            SCHED_RENDER: begin
                // A done on the final timeout cycle wins over the abort.
                if (render_done_in) begin
                    state_nxt = SCHED_WAIT_VBLANK;
                end else if (render_cnt == TMO_LAST) begin
                    state_nxt   = SCHED_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            SCHED_WAIT_VBLANK: begin
                if (vblank_in) begin
                    state_nxt = SCHED_SWAP;
                end
            end
            SCHED_SWAP: begin
                state_nxt = SCHED_IDLE;
            end
            default: begin
                state_nxt = SCHED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                 <= SCHED_IDLE;
            armed                 <= 1'b0;
            render_cnt            <= '0;
            pos_vec_out           <= VEC3_ZERO;
            dir_vec_out           <= VEC3_ZERO;
            frames_out            <= '0;
            vblanks_per_frame_out <= 8'd0;
            timeout_out           <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;

            if (state == SCHED_START) begin
                render_cnt <= '0;
            end else if (state == SCHED_RENDER) begin
                render_cnt <= render_cnt + TMO_BITS'(1);
            end

            // Camera is sampled once per frame so the whole frame renders one viewpoint.
            if ((state == SCHED_IDLE) && (state_nxt == SCHED_START)) begin
                pos_vec_out <= cam_pos_in;
                dir_vec_out <= cam_dir_in;
            end

            if (timeout_hit) begin
                timeout_out <= 1'b1;
            end

            if (swap_now) begin
                frames_out            <= frames_out + FRAME_CNT_BITS'(1);
                vblanks_per_frame_out <= vblank_edges;
            end
        end
    end

    frame_scheduler_edge_counter u_vblank_edges (
        .core_clk (clk_in),
        .rst      (rst_in),
        .level    (vblank_in),
        .clear    (swap_now),
        .count    (vblank_edges)
    );

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: per-cycle comparison against a frame-level model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_scheduler
    import frame_scheduler_pkg::*;
;

    localparam int TMO        = 16;
    localparam int FRAME_BITS = 16;

    logic                  clk;
    logic                  rst;
    logic                  pause;
    logic                  vblank;
    logic                  done;
    vec3                   cam_pos;
    vec3                   cam_dir;
    vec3                   pos_out;
    vec3                   dir_out;
    logic                  start_out;
    logic                  swap_out;
    logic [FRAME_BITS-1:0] frames;
    logic [7:0]            vpf;
    logic                  tmo_out;

    int tests = 0;
    int fails = 0;

    frame_scheduler #(
        .TIMEOUT_CYCLES (TMO),
        .FRAME_CNT_BITS (FRAME_BITS)
    ) dut (
        .clk_in                (clk),
        .rst_in                (rst),
        .pause_in              (pause),
        .vblank_in             (vblank),
        .render_done_in        (done),
        .cam_pos_in            (cam_pos),
        .cam_dir_in            (cam_dir),
        .pos_vec_out           (pos_out),
        .dir_vec_out           (dir_out),
        .render_start_out      (start_out),
        .swap_buffers_out      (swap_out),
        .frames_out            (frames),
        .vblanks_per_frame_out (vpf),
        .timeout_out           (tmo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Tracks the frame as a sequence of phases: a start pulse, a render of age N,
    // a wait for blanking, a swap pulse; plus the swap/edge bookkeeping.
    bit  m_valid = 0;
    bit  m_armed, m_start, m_swap, m_rendering, m_waiting, m_tmo, m_prev_vb;
    int  m_age, m_frames, m_vpf, m_edges;
    vec3 m_pos, m_dir;

    task automatic model_step();
        bit rise;
        if (rst) begin
            m_valid = 1; m_armed = 0; m_start = 0; m_swap = 0; m_rendering = 0;
            m_waiting = 0; m_tmo = 0; m_prev_vb = 0; m_age = 0; m_frames = 0;
            m_vpf = 0; m_edges = 0; m_pos = '0; m_dir = '0;
        end else begin
            rise      = vblank && !m_prev_vb;
            m_prev_vb = vblank;
            if (m_swap) begin
                m_frames = (m_frames + 1) % (1 << FRAME_BITS);
                m_vpf    = m_edges;
                m_edges  = rise ? 1 : 0;
            end else if (rise && m_edges < 255) begin
                m_edges = m_edges + 1;
            end

            if (m_start) begin
                m_start = 0; m_rendering = 1; m_age = 0;
            end else if (m_swap) begin
                m_swap = 0;
            end else if (m_rendering) begin
                m_age = m_age + 1;
                if (done) begin
                    m_rendering = 0; m_waiting = 1;
                end else if (m_age == TMO) begin
                    m_rendering = 0; m_tmo = 1;
                end
            end else if (m_waiting) begin
                if (vblank) begin
                    m_waiting = 0; m_swap = 1;
                end
            end else if (m_armed && !pause) begin
                m_start = 1; m_pos = cam_pos; m_dir = cam_dir;
            end
            m_armed = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("render_start", 64'(start_out), 64'(m_start));
            chk("swap_buffers", 64'(swap_out), 64'(m_swap));
            chk("frames", 64'(frames), 64'(m_frames));
            chk("vblanks_per_frame", 64'(vpf), 64'(m_vpf));
            chk("timeout", 64'(tmo_out), 64'(m_tmo));
            chk("pos_vec", {16'd0, pos_out}, {16'd0, m_pos});
            chk("dir_vec", {16'd0, dir_out}, {16'd0, m_dir});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (start_out) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_swap(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (swap_out) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int swaps;
        int starts;

        rst    = 1'b1;
        pause  = 1'b0;
        vblank = 1'b0;
        done   = 1'b0;
        cam_pos = '{x: 16'sh0000, y: 16'sh0000, z: 16'shFE80};   // z = -1.5
        cam_dir = '{x: 16'sh0000, y: 16'sh0000, z: FP_ONE};
        repeat (3) tick();

        // Reset state
        chk("rst_frames", 64'(frames), 64'd0);
        chk("rst_timeout", 64'(tmo_out), 64'd0);
        chk("rst_vpf", 64'(vpf), 64'd0);
        chk("rst_start", 64'(start_out), 64'd0);
        chk("rst_pos", {16'd0, pos_out}, 64'd0);

        // Reset release: START two cycles later, camera latched and held
        rst = 1'b0;
        wait_start(4, n);
        chk("start_latency", 64'(n), 64'd2);
        cam_pos = '{x: 16'sh0040, y: 16'sh0020, z: FP_ONE};
        pause = 1'b1;
        tick();
        chk("pos_z_held_1", {48'd0, pos_out.z}, 64'h0000_0000_0000_FE80);
        repeat (4) tick();
        chk("pos_z_held_2", {48'd0, pos_out.z}, 64'h0000_0000_0000_FE80);

        // Done with vblank low for 100 cycles, then vblank high
        done = 1'b1;
        tick();
        done = 1'b0;
        swaps = 0; starts = 0;
        repeat (100) begin
            tick();
            if (swap_out) swaps++;
        end
        chk("no_swap_outside_vblank", 64'(swaps), 64'd0);
        vblank = 1'b1;
        swaps = 0;
        repeat (10) begin
            tick();
            if (swap_out) swaps++;
            if (start_out) starts++;
        end
        chk("one_swap_in_vblank", 64'(swaps), 64'd1);
        chk("frames_0_to_1", 64'(frames), 64'd1);
        chk("vpf_single_edge", 64'(vpf), 64'd1);
        chk("paused_no_start", 64'(starts), 64'd0);

        // Done while vblank already high: SWAP two cycles after done
        do_reset();
        vblank = 1'b1;
        pause  = 1'b0;
        wait_start(4, n);
        pause = 1'b1;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_swap(5, n);
        chk("done_to_swap_in_blank", 64'(n + 1), 64'd2);

        // Done coincident with the final timeout cycle: done wins
        do_reset();
        vblank = 1'b0;
        pause  = 1'b0;
        wait_start(4, n);
        pause = 1'b1;
        repeat (TMO) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("tie_timeout_clear", 64'(tmo_out), 64'd0);
        vblank = 1'b1;
        wait_swap(5, n);
        chk("tie_swap_seen", 64'(n), 64'd1);
        tick();
        chk("tie_frames", 64'(frames), 64'd1);
        chk("tie_timeout_still_clear", 64'(tmo_out), 64'd0);

        // Timeout without done
        do_reset();
        vblank = 1'b0;
        pause  = 1'b0;
        wait_start(4, n);
        swaps = 0;
        repeat (TMO) begin
            tick();
            if (swap_out) swaps++;
        end
        chk("timeout_not_yet", 64'(tmo_out), 64'd0);
        tick();
        chk("timeout_set", 64'(tmo_out), 64'd1);
        chk("timeout_no_swap", 64'(swaps + (swap_out ? 1 : 0)), 64'd0);
        wait_start(3, n);
        chk("restart_after_timeout", 64'(n), 64'd1);
        pause = 1'b1;
        chk("timeout_sticky", 64'(tmo_out), 64'd1);

        // Vblank edge counting: 3 edges in a frame, then 300 while paused
        do_reset();
        vblank = 1'b0;
        pause  = 1'b0;
        wait_start(4, n);
        pause = 1'b1;
        repeat (2) begin
            vblank = 1'b1; tick(); tick();
            vblank = 1'b0; tick(); tick();
        end
        vblank = 1'b1;
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_swap(5, n);
        tick();
        chk("vpf_three_edges", 64'(vpf), 64'd3);
        vblank = 1'b0;
        tick();
        starts = 0;
        repeat (300) begin
            vblank = 1'b1; tick();
            if (start_out) starts++;
            vblank = 1'b0; tick();
            if (start_out) starts++;
        end
        chk("no_start_while_paused", 64'(starts), 64'd0);
        pause = 1'b0;
        wait_start(3, n);
        chk("start_after_unpause", 64'(n), 64'd1);
        pause = 1'b1;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        vblank = 1'b1;
        wait_swap(5, n);
        tick();
        chk("vpf_saturated", 64'(vpf), 64'd255);
        chk("frames_two", 64'(frames), 64'd2);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
